// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the prioritized, vectored interrupt controller.
// Holds the controller state names, default vector table placement and the
// largest supported number of interrupt sources.
package irq_pkg;

    localparam int          IRQ_MAX_SRC    = 8;
    localparam logic [31:0] IRQ_VEC_BASE   = 32'h0000_0018;
    localparam logic [31:0] IRQ_VEC_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Handler address for a source index, wrapping modulo 2^32.
    function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [31:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: request/acknowledge/end-of-interrupt handshake between the
// interrupt controller (master) and the CPU control unit (slave).
interface irq_ctrl_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = $clog2(N_SRC);

    logic            cpu_int_en;
    logic            irq_ack;
    logic            irq_eoi;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic [31:0]     irq_vec;

    modport master (
        output irq_req, irq_id, irq_vec,
        input  cpu_int_en, irq_ack, irq_eoi
    );

    modport slave (
        input  irq_req, irq_id, irq_vec,
        output cpu_int_en, irq_ack, irq_eoi
    );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder with a valid flag.
// Index 0 has the highest priority.
module irq_prio_enc #(
    parameter int W = 4
) (
    input  logic [W-1:0]         req,
    output logic [$clog2(W)-1:0] idx,
    output logic                 valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = ($clog2(W))'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritized, vectored interrupt controller.
// Latches rising edges of the source lines into a pending register, filters
// them with a software mask, and hands the highest-priority request to the
// CPU through a request/ack/EOI handshake. The handler vector follows the
// latched source index.
// Optional build macro: IRQ_NEST_EN enables preemption of a running handler
// by a strictly higher-priority source.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    irq_ctrl_if.master       bus,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service
);

    localparam int ID_W = $clog2(N_SRC);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_REQ     = REQ;
    localparam logic [1:0] ST_SERVICE = SERVICE;

    logic [1:0]       state;
    logic [ID_W-1:0]  id_q;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] src_edge;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] is_set;
    logic [N_SRC-1:0] is_clr;
    logic [N_SRC-1:0] is_after_eoi;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  is_low_idx;
    logic             win_valid;
    logic             is_valid;
    logic             ack_fire;
    logic             eoi_fire;
    logic             nest_ok;

    assign src_edge = irq_src & ~src_q;
    assign cand     = pending & mask_q;

    irq_prio_enc #(.W(N_SRC)) u_cand_enc (
        .req   (cand),
        .idx   (win_idx),
        .valid (win_valid)
    );

    irq_prio_enc #(.W(N_SRC)) u_eoi_enc (
        .req   (in_service),
        .idx   (is_low_idx),
        .valid (is_valid)
    );

    assign ack_fire = (state == ST_REQ) && bus.irq_ack;
    assign eoi_fire = (state == ST_SERVICE) && bus.irq_eoi && is_valid;

`ifdef IRQ_NEST_EN
    assign nest_ok = win_valid && is_valid && (win_idx < is_low_idx) && bus.cpu_int_en;
`else
    assign nest_ok = 1'b0;
`endif

    // Decode the ack and EOI events into per-source set/clear vectors.
    always_comb begin
        pend_clr = '0;
        is_set   = '0;
        is_clr   = '0;
        if (ack_fire) begin
            pend_clr[id_q] = 1'b1;
            is_set[id_q]   = 1'b1;
        end
        if (eoi_fire) begin
            is_clr[is_low_idx] = 1'b1;
        end
        is_after_eoi = in_service & ~is_clr;
    end

    // Handshake sequencing and latching of the granted source index.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            id_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid && bus.cpu_int_en) begin
                        state <= ST_REQ;
                        id_q  <= win_idx;
                    end
                end
                ST_REQ: begin
                    if (bus.irq_ack) begin
                        state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (eoi_fire) begin
                        if (is_after_eoi == '0) begin
                            state <= ST_IDLE;
                        end
                    end else if (nest_ok) begin
                        state <= ST_REQ;
                        id_q  <= win_idx;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Edge history, mask, pending and in-service registers; a new edge beats an ack clear.
    always_ff @(posedge clk) begin
        if (Rst) begin
            src_q      <= irq_src;
            mask_q     <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            src_q      <= irq_src;
            pending    <= (pending & ~pend_clr) | src_edge;
            in_service <= is_after_eoi | is_set;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign bus.irq_req = (state == ST_REQ);
    assign bus.irq_id  = id_q;
    assign bus.irq_vec = irq_vector(VEC_BASE, VEC_STRIDE, 32'(id_q));

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: self-checking bench for irq_ctrl (4 sources, default vectors).
// Directed table rows, hand-written nesting/reset sequences, then randomized
// traffic compared against a queue-based behavioural model.
module tb_irq_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;

    int total = 0;
    int bad   = 0;

    irq_ctrl_if #(.N_SRC(N)) bus ();

    irq_ctrl #(.N_SRC(N)) dut (
        .clk        (clk),
        .Rst        (rst),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .bus        (bus.master),
        .pending    (pending),
        .in_service (in_service)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  s;
        logic        mwe;
        logic [3:0]  md;
        logic [2:0]  ctl;
        logic        ereq;
        logic [1:0]  eid;
        logic [31:0] evec;
        logic [3:0]  ep;
        logic [3:0]  eis;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: pending/mask bits plus a list of sources in service.
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [3:0] m_prev;
    bit       m_req;
    int       m_id;
    int       m_svc[$];

    function automatic vec_t mk(input logic r, input logic [3:0] s, input logic mwe,
                                input logic [3:0] md, input logic [2:0] ctl,
                                input logic ereq, input logic [1:0] eid,
                                input logic [31:0] evec, input logic [3:0] ep,
                                input logic [3:0] eis);
        vec_t v;
        v = '{r, s, mwe, md, ctl, ereq, eid, evec, ep, eis};
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ctl = {cpu_int_en, irq_ack, irq_eoi}; drives, clocks once, waits 1 unit past the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] s, input logic mwe,
                                 input logic [3:0] md, input logic [2:0] ctl);
        rst            = r;
        irq_src        = s;
        mask_we        = mwe;
        mask_wdata     = md;
        bus.cpu_int_en = ctl[2];
        bus.irq_ack    = ctl[1];
        bus.irq_eoi    = ctl[0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ereq, input logic [1:0] eid,
                               input logic [31:0] evec, input logic [3:0] ep,
                               input logic [3:0] eis);
        cmp({tag, ".req"},  32'(bus.irq_req), 32'(ereq));
        cmp({tag, ".id"},   32'(bus.irq_id),  32'(eid));
        cmp({tag, ".vec"},  bus.irq_vec,      evec);
        cmp({tag, ".pend"}, 32'(pending),     32'(ep));
        cmp({tag, ".isr"},  32'(in_service),  32'(eis));
    endtask

    task automatic modelStep(input logic r, input logic [3:0] s, input logic mwe,
                             input logic [3:0] md, input logic [2:0] ctl);
        int       low_cand;
        int       low_svc;
        int       low_pos;
        bit [3:0] clr;
        low_cand = -1;
        low_svc  = 99;
        low_pos  = -1;
        clr      = '0;
        if (r) begin
            m_pend = '0;
            m_mask = '0;
            m_req  = 1'b0;
            m_id   = 0;
            m_svc.delete();
            m_prev = s;
            return;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (m_pend[i] && m_mask[i]) low_cand = i;
        end
        for (int k = 0; k < m_svc.size(); k++) begin
            if (m_svc[k] < low_svc) begin
                low_svc = m_svc[k];
                low_pos = k;
            end
        end
        if (m_req) begin
            if (ctl[1]) begin
                m_req = 1'b0;
                m_svc.push_back(m_id);
                clr[m_id] = 1'b1;
            end
        end else if (m_svc.size() == 0) begin
            if (low_cand >= 0 && ctl[2]) begin
                m_req = 1'b1;
                m_id  = low_cand;
            end
        end else if (ctl[0]) begin
            m_svc.delete(low_pos);
        end
`ifdef IRQ_NEST_EN
        else if (low_cand >= 0 && low_cand < low_svc && ctl[2]) begin
            m_req = 1'b1;
            m_id  = low_cand;
        end
`endif
        m_pend = (m_pend & ~clr) | (s & ~m_prev);
        if (mwe) m_mask = md;
        m_prev = s;
    endtask

    function automatic logic [3:0] modelInService();
        logic [3:0] v;
        v = '0;
        foreach (m_svc[k]) v[m_svc[k]] = 1'b1;
        return v;
    endfunction

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [3:0] cur_src;
        logic       r, mwe, ereq_hold;
        logic [3:0] s, md;
        logic [2:0] ctl;

        rst = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
        bus.cpu_int_en = 1'b0; bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;

        // Directed rows: basic request, two-source priority, mask/int_en, sticky request, set-wins.
        tbl.push_back(mk(1'b1, 4'h0, 1'b0, 4'h0, 3'b100, 1'b0, 2'd0, 32'h18, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h2, 3'b100, 1'b0, 2'd0, 32'h18, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h2, 1'b0, 4'h0, 3'b100, 1'b0, 2'd0, 32'h18, 4'h2, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b1, 2'd1, 32'h1C, 4'h2, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b110, 1'b0, 2'd1, 32'h1C, 4'h0, 4'h2));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b101, 1'b0, 2'd1, 32'h1C, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b0, 2'd1, 32'h1C, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'hF, 3'b100, 1'b0, 2'd1, 32'h1C, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'hC, 1'b0, 4'h0, 3'b100, 1'b0, 2'd1, 32'h1C, 4'hC, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b1, 2'd2, 32'h20, 4'hC, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b110, 1'b0, 2'd2, 32'h20, 4'h8, 4'h4));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b101, 1'b0, 2'd2, 32'h20, 4'h8, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b1, 2'd3, 32'h24, 4'h8, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b110, 1'b0, 2'd3, 32'h24, 4'h0, 4'h8));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b101, 1'b0, 2'd3, 32'h24, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0, 3'b100, 1'b0, 2'd3, 32'h24, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 4'h0, 3'b100, 1'b0, 2'd3, 32'h24, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b0, 2'd3, 32'h24, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h1, 3'b000, 1'b0, 2'd3, 32'h24, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0, 2'd3, 32'h24, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b1, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0, 3'b000, 1'b1, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b000, 1'b1, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b010, 1'b0, 2'd0, 32'h18, 4'h0, 4'h1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b001, 1'b0, 2'd0, 32'h18, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h1, 3'b100, 1'b0, 2'd0, 32'h18, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 4'h0, 3'b100, 1'b0, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b1, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 4'h0, 3'b110, 1'b0, 2'd0, 32'h18, 4'h1, 4'h1));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 4'h0, 3'b101, 1'b0, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b100, 1'b1, 2'd0, 32'h18, 4'h1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b110, 1'b0, 2'd0, 32'h18, 4'h0, 4'h1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b101, 1'b0, 2'd0, 32'h18, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 3'b111, 1'b0, 2'd0, 32'h18, 4'h0, 4'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].s, tbl[i].mwe, tbl[i].md, tbl[i].ctl);
            checkOutput($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eid, tbl[i].evec,
                        tbl[i].ep, tbl[i].eis);
        end

        // Source 2 in service, then an edge on higher-priority source 0.
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 3'b100);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'hF, 3'b100);
        applyStimulus(1'b0, 4'h4, 1'b0, 4'h0, 3'b100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b100);
        checkOutput("nest.req2", 1'b1, 2'd2, 32'h20, 4'h4, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b110);
        checkOutput("nest.ack2", 1'b0, 2'd2, 32'h20, 4'h0, 4'h4);
        applyStimulus(1'b0, 4'h1, 1'b0, 4'h0, 3'b100);
        checkOutput("nest.edge0", 1'b0, 2'd2, 32'h20, 4'h1, 4'h4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b100);
`ifdef IRQ_NEST_EN
        checkOutput("nest.req0", 1'b1, 2'd0, 32'h18, 4'h1, 4'h4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b110);
        checkOutput("nest.ack0", 1'b0, 2'd0, 32'h18, 4'h0, 4'h5);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b101);
        checkOutput("nest.eoi1", 1'b0, 2'd0, 32'h18, 4'h0, 4'h4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b101);
        checkOutput("nest.eoi2", 1'b0, 2'd0, 32'h18, 4'h0, 4'h0);
`else
        checkOutput("nest.hold1", 1'b0, 2'd2, 32'h20, 4'h1, 4'h4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b100);
        checkOutput("nest.hold2", 1'b0, 2'd2, 32'h20, 4'h1, 4'h4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b101);
        checkOutput("nest.eoi", 1'b0, 2'd2, 32'h20, 4'h1, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b100);
        checkOutput("nest.req0", 1'b1, 2'd0, 32'h18, 4'h1, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b110);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b101);
        checkOutput("nest.done", 1'b0, 2'd0, 32'h18, 4'h0, 4'h0);
`endif

        // Reset while in service with source 3 pending, sources held high through release.
        applyStimulus(1'b0, 4'h4, 1'b0, 4'h0, 3'b100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 3'b110);
        applyStimulus(1'b0, 4'h8, 1'b0, 4'h0, 3'b100);
        checkOutput("rst.before", 1'b0, 2'd2, 32'h20, 4'h8, 4'h4);
        applyStimulus(1'b1, 4'hF, 1'b0, 4'h0, 3'b100);
        checkOutput("rst.during", 1'b0, 2'd0, 32'h18, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'hF, 1'b1, 4'hF, 3'b100);
        applyStimulus(1'b0, 4'hF, 1'b0, 4'h0, 3'b100);
        applyStimulus(1'b0, 4'hF, 1'b0, 4'h0, 3'b100);
        checkOutput("rst.held", 1'b0, 2'd0, 32'h18, 4'h0, 4'h0);

        // Randomized traffic against the behavioural model.
        cur_src = '0;
        applyStimulus(1'b1, cur_src, 1'b0, 4'h0, 3'b100);
        modelStep(1'b1, cur_src, 1'b0, 4'h0, 3'b100);
        for (int i = 0; i < 3000; i++) begin
            r       = ($urandom_range(0, 199) == 0);
            cur_src = cur_src ^ (4'($urandom) & 4'($urandom));
            s       = cur_src;
            mwe     = ($urandom_range(0, 15) == 0);
            md      = 4'($urandom);
            ctl[2]  = ($urandom_range(0, 7) != 0);
            ctl[1]  = ($urandom_range(0, 2) == 0);
            ctl[0]  = ($urandom_range(0, 3) == 0);
            modelStep(r, s, mwe, md, ctl);
            applyStimulus(r, s, mwe, md, ctl);
            ereq_hold = m_req;
            checkOutput($sformatf("rnd%0d", i), ereq_hold, m_id[1:0],
                        32'h18 + 32'(m_id) * 32'd4, m_pend, modelInService());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Prioritized, vectored interrupt controller sitting between external interrupt sources and the multi-cycle ARM CPU core. It latches source edges into a pending register, applies a software-written mask, and selects the highest-priority request. It then runs a request/acknowledge/end-of-interrupt handshake with the CPU control unit, which samples the request only at instruction boundaries. It supplies the handler vector the CPU loads into PC on interrupt entry.

## Interface
- `N_SRC`, 4: number of interrupt sources (2..8); index 0 is highest priority
- `VEC_BASE`, 32'h0000_0018: handler address of source 0
- `VEC_STRIDE`, 4: byte distance between consecutive source vectors
- `clk`  in  1  system clock, all state updates on rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `irq_src`  in  N_SRC  raw source lines, rising-edge sensitive
- `mask_we`  in  1  write strobe for mask register
- `mask_wdata`  in  N_SRC  new mask (1 = source enabled)
- `cpu_int_en`  in  1  CPU interrupts enabled (CPSR I bit clear)
- `irq_ack`  in  1  CPU accepts current request at instruction boundary
- `irq_eoi`  in  1  CPU finished handler (return from interrupt)
- `irq_req`  out  1  interrupt request to CPU control unit
- `irq_id`  out  $clog2(N_SRC)  selected source index
- `irq_vec`  out  32  handler address for `irq_id`
- `pending`  out  N_SRC  pending register
- `in_service`  out  N_SRC  in-service register

## Operation
- Edge detect: `src_q` holds previous `irq_src`; pending[i] set on edge where irq_src[i]=1 and src_q[i]=0.
- Candidate set = pending & mask; winner = lowest set index.
- States: IDLE, REQ, SERVICE.
- IDLE: if candidate set nonzero and `cpu_int_en`=1 → REQ; latch winner into `irq_id`.
- REQ: `irq_req`=1; `irq_id` frozen. Masking the source or dropping `cpu_int_en` does not withdraw the request. `irq_ack`=1 → SERVICE: set in_service[irq_id], clear pending[irq_id].
- SERVICE: `irq_eoi`=1 → clear the lowest-index set in_service bit; go to IDLE if in_service becomes zero, else stay in SERVICE.
- `irq_vec` = VEC_BASE + irq_id*VEC_STRIDE, 32-bit modulo-2^32 arithmetic, combinational from `irq_id`.
- Same-cycle set and clear of one pending bit (new edge during ack): set wins; bit stays 1.
- `irq_ack` outside REQ and `irq_eoi` with in_service=0 are ignored.
- `mask_we` takes effect on the next edge. It never alters pending or in_service.

## Timing
- Reset values: `irq_req`=0, `irq_id`=0, `irq_vec`=VEC_BASE, `pending`=0, `in_service`=0, mask=0, state IDLE. `src_q` is loaded with the current `irq_src`, so a line already high at reset release creates no edge.
- Latency: irq_src rises before edge t → pending set at t → `irq_req`=1 after t+1, if masked-in and `cpu_int_en`=1.
- Ack: `irq_ack` sampled at edge with `irq_req`=1 → `irq_req`=0 and in_service set after that edge.
- Earliest re-request after EOI: one cycle in IDLE, then REQ.
- Reset mid-operation discards all pending, in-service and request state within the same edge.

## Configuration
- `IRQ_NEST_EN` defined: in SERVICE, a candidate with index lower than the lowest set in_service bit, with `cpu_int_en`=1, moves to REQ. Ack then adds a second in_service bit; each EOI retires the highest-priority in-service bit.
- `IRQ_NEST_EN` undefined: SERVICE ignores all new candidates until EOI. At most one in_service bit is ever set.

## Structure
- Package `irq_pkg`: state enum (IDLE/REQ/SERVICE), default `VEC_BASE`, `VEC_STRIDE`, maximum N_SRC constant.
- Sub-module `irq_prio_enc`: N_SRC-bit lowest-index priority encoder with a valid flag. Used for candidate selection and for EOI bit selection.

## Test plan
- Mask=4'b0010, pulse irq_src[1], `cpu_int_en`=1 → `irq_req`=1 two edges later, `irq_id`=1, `irq_vec`=32'h1C; ack → pending=0, in_service=4'b0010; EOI → in_service=0, IDLE.
- Mask=4'b1111, simultaneous edges on sources 3 and 2 → first request id=2, `irq_vec`=32'h20; after ack+EOI, second request id=3, `irq_vec`=32'h24.
- Edge on masked source 0 → no request; later write mask=4'b0001 → `irq_req`=1 one cycle after the write; `cpu_int_en`=0 holds IDLE with pending=4'b0001.
- In REQ, clear mask and drop `cpu_int_en` → `irq_req` stays 1 until ack.
- Serving source 2, edge on source 0 → with `IRQ_NEST_EN`: new request id=0, in_service=4'b0101 after ack, first EOI clears bit 0. Without the macro: no request until EOI.
- Assert `Rst` while in SERVICE with pending=4'b1000 → all outputs at reset values next edge. Holding `irq_src`=4'b1111 high through release → no request.
